// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_t     : sequencer states (IDLE, CALC, DONE)
//   digit_t     : recoded Booth digit {0, +1, +2, -1, -2}
//   booth_width : internal operand width W for operand width N (always even)
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // One extra bit so unsigned operands stay positive, rounded up to even.
    function automatic int unsigned booth_width(input int unsigned n);
        return ((n % 32'd2) == 32'd0) ? n + 32'd2 : n + 32'd1;
    endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Request/result bundle for booth_r4_multiplier.
//   master : start, is_signed, A, B (and acc) out; product, ready, done in
//   slave  : the reverse, used by the multiplier
// Optional macro BOOTH_ACCUM_EN adds the acc request bit.
interface booth_r4_multiplier_if #(
    parameter int unsigned N = 8
);

    logic             start;
    logic             is_signed;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
`ifdef BOOTH_ACCUM_EN
    logic             acc;
`endif
    logic [2*N-1:0]   product;
    logic             ready;
    logic             done;

`ifdef BOOTH_ACCUM_EN
    modport master (output start, is_signed, A, B, acc, input product, ready, done);
    modport slave  (input start, is_signed, A, B, acc, output product, ready, done);
`else
    modport master (output start, is_signed, A, B, input product, ready, done);
    modport slave  (input start, is_signed, A, B, output product, ready, done);
`endif

endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: multiplier triplet {b[2i+1], b[2i], b[2i-1]} to digit.
//   triplet : 3-bit window of the multiplier
//   digit_c : combinational digit code
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     digit_c
);

    always_comb begin
        digit_c = ZERO;
        case (triplet)
            3'b001, 3'b010: digit_c = POS1;
            3'b011:         digit_c = POS2;
            3'b100:         digit_c = NEG2;
            3'b101, 3'b110: digit_c = NEG1;
            default:        digit_c = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, N x N -> 2N, two multiplier bits per cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of booth_r4_multiplier_if (start/is_signed/A/B in,
//              product/ready/done out)
// Optional macro BOOTH_ACCUM_EN: acc=1 at accept adds the result into product.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_r4_multiplier_if.slave  bus
);

    localparam int unsigned W  = booth_width(N);
    localparam int unsigned PW = W + 2;
    localparam int unsigned K  = W / 2;
    localparam int unsigned CW = $clog2(K);
    localparam int unsigned RW = 2 * N;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_ext;
    logic [PW-1:0]   p;
    logic [W-1:0]    q;
    logic            q_m1;
`ifdef BOOTH_ACCUM_EN
    logic            acc_q;
`endif

    digit_t          digit_c;
    logic [PW-1:0]   a_x_c;
    logic [PW-1:0]   addend_c;
    logic [PW-1:0]   p_sum_c;
    logic [RW-1:0]   res_c;
    logic            sa_c;
    logic            sb_c;

    booth_r4_encoder u_enc (
        .triplet ({q[1:0], q_m1}),
        .digit_c (digit_c)
    );

    // Digit times multiplicand added into the upper partial product.
    always_comb begin
        sa_c     = bus.is_signed & bus.A[N-1];
        sb_c     = bus.is_signed & bus.B[N-1];
        a_x_c    = {{2{a_ext[W-1]}}, a_ext};
        addend_c = '0;
        case (digit_c)
            POS1:    addend_c = a_x_c;
            POS2:    addend_c = a_x_c << 1;
            NEG1:    addend_c = -a_x_c;
            NEG2:    addend_c = -(a_x_c << 1);
            default: addend_c = '0;
        endcase
        p_sum_c = p + addend_c;
        res_c   = RW'({p, q});
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_ext       <= '0;
            p           <= '0;
            q           <= '0;
            q_m1        <= 1'b0;
`ifdef BOOTH_ACCUM_EN
            acc_q       <= 1'b0;
`endif
            bus.product <= '0;
            bus.ready   <= 1'b1;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_ext     <= {{(W-N){sa_c}}, bus.A};
                        q         <= {{(W-N){sb_c}}, bus.B};
                        q_m1      <= 1'b0;
                        p         <= '0;
                        cnt       <= '0;
`ifdef BOOTH_ACCUM_EN
                        acc_q     <= bus.acc;
`endif
                        bus.ready <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    // Arithmetic shift of {p_sum, q, q_m1} right by two.
                    p    <= {{2{p_sum_c[PW-1]}}, p_sum_c[PW-1:2]};
                    q    <= {p_sum_c[1:0], q[W-1:2]};
                    q_m1 <= q[1];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(K - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef BOOTH_ACCUM_EN
                    bus.product <= acc_q ? bus.product + res_c : res_c;
`else
                    bus.product <= res_c;
`endif
                    bus.done    <= 1'b1;
                    bus.ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed bench for booth_r4_multiplier: N=8 and N=7 instances, plus an
// N=16 accumulating instance when BOOTH_ACCUM_EN is defined.
module tb_booth_r4_multiplier;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    booth_r4_multiplier_if #(.N(8)) bus8 ();
    booth_r4_multiplier_if #(.N(7)) bus7 ();

    booth_r4_multiplier #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    booth_r4_multiplier #(.N(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7.slave));

`ifdef BOOTH_ACCUM_EN
    booth_r4_multiplier_if #(.N(16)) bus16 ();
    booth_r4_multiplier #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [15:0] exp);
        int cyc;
        @(negedge clk);
        chk({tag, "_ready_before"}, 64'(bus8.ready), 64'd1);
        bus8.A = a; bus8.B = b; bus8.is_signed = sgn; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.A = ~a; bus8.B = ~b; bus8.is_signed = ~sgn;
        chk({tag, "_busy"}, 64'(bus8.ready), 64'd0);
        cyc = 0;
        while (cyc < 20 && bus8.done !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd6);
        chk({tag, "_product"}, 64'(bus8.product), 64'(exp));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus8.done), 64'd0);
    endtask

    task automatic mul7(input string tag, input logic [6:0] a, input logic [6:0] b,
                        input logic sgn, input logic [13:0] exp);
        int cyc;
        @(negedge clk);
        bus7.A = a; bus7.B = b; bus7.is_signed = sgn; bus7.start = 1'b1;
        @(posedge clk); #1;
        bus7.start = 1'b0; bus7.A = '0; bus7.B = '0;
        cyc = 0;
        while (cyc < 20 && bus7.done !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd5);
        chk({tag, "_product"}, 64'(bus7.product), 64'(exp));
    endtask

`ifdef BOOTH_ACCUM_EN
    task automatic mul16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic accm, input logic [31:0] exp);
        int cyc;
        @(negedge clk);
        bus16.A = a; bus16.B = b; bus16.is_signed = 1'b1; bus16.acc = accm;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.acc = ~accm;
        cyc = 0;
        while (cyc < 30 && bus16.done !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd10);
        chk({tag, "_product"}, 64'(bus16.product), 64'(exp));
    endtask
`endif

    initial begin
        int pulses;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.is_signed = 1'b0; bus8.A = '0; bus8.B = '0;
        bus7.start = 1'b0; bus7.is_signed = 1'b0; bus7.A = '0; bus7.B = '0;
`ifdef BOOTH_ACCUM_EN
        bus8.acc = 1'b0; bus7.acc = 1'b0;
        bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.A = '0; bus16.B = '0;
        bus16.acc = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_product", 64'(bus8.product), 64'd0);
        chk("reset_ready", 64'(bus8.ready), 64'd1);
        chk("reset_done", 64'(bus8.done), 64'd0);

        // Signed corners.
        mul8("s_127x-128", 8'h7F, 8'h80, 1'b1, 16'hC080);
        mul8("s_-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
        mul8("s_-3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        mul8("s_-1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001);

        // Reset during the third CALC cycle.
        @(negedge clk);
        bus8.A = 8'd7; bus8.B = 8'd9; bus8.is_signed = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_product", 64'(bus8.product), 64'd0);
        chk("midrst_ready", 64'(bus8.ready), 64'd1);
        chk("midrst_done", 64'(bus8.done), 64'd0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);

        // Unsigned corners.
        mul8("u_255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        mul8("u_128x2", 8'h80, 8'h02, 1'b0, 16'h0100);
        mul8("u_0x200", 8'h00, 8'hC8, 1'b0, 16'h0000);

        // Start during CALC is ignored.
        @(negedge clk);
        bus8.A = 8'd5; bus8.B = 8'd6; bus8.is_signed = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        bus8.A = 8'd3; bus8.B = 8'd3; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        pulses = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) pulses++;
        end
        chk("ignore_product", 64'(bus8.product), 64'd30);
        chk("ignore_one_done", 64'(pulses), 64'd1);
        chk("ignore_ready", 64'(bus8.ready), 64'd1);

        // Reset and start on the same edge: nothing accepted.
        @(negedge clk);
        rst = 1'b1; bus8.A = 8'd3; bus8.B = 8'd3; bus8.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus8.start = 1'b0;
        chk("rststart_ready", 64'(bus8.ready), 64'd1);
        chk("rststart_product", 64'(bus8.product), 64'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) pulses++;
        end
        chk("rststart_no_done", 64'(pulses), 64'd0);

        // Odd width.
        mul7("n7_-64x63", 7'h40, 7'h3F, 1'b1, 14'h3040);
        mul7("n7_u127x127", 7'h7F, 7'h7F, 1'b0, 14'h3F01);

`ifdef BOOTH_ACCUM_EN
        begin
            logic [31:0] exp32;
            mul16("acc_100x100", 16'd100, 16'd100, 1'b0, 32'd10000);
            mul16("acc_200x200", 16'd200, 16'd200, 1'b1, 32'd50000);
            exp32 = 32'd50000;
            for (int i = 0; i < 5; i++) begin
                exp32 = 32'(exp32 + 32'd1073676289);
                mul16("acc_32767sq", 16'd32767, 16'd32767, 1'b1, exp32);
            end
            chk("acc_wrap_final", 64'(bus16.product), 64'd1073464149);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
